// File: rtl/synth_pkg.sv
// synth_pkg: shared constants and sequencer write FSM states for the synth cfg block
package synth_pkg;
  localparam int CFG_ADDR_BITS   = 3;
  localparam int CFG_WORDS       = 8;
  localparam int OSC_PERIOD_BASE = 0;
  localparam int MOD_PERIOD_BASE = 2;
  localparam int PAT_REST_BIT    = 15;
  typedef enum logic [1:0] {IDLE = 2'd0, WR_LO = 2'd1, WR_HI = 2'd2} seq_state_e;
endpackage

// File: rtl/seq_tempo_counter.sv
// seq_tempo_counter: reload/decrement step timer; ticks on the first run cycle and every tempo+1 cycles after
module seq_tempo_counter #(
  parameter int TEMPO_BITS = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [TEMPO_BITS-1:0] tempo,
  output logic                  tick
);
  logic [TEMPO_BITS-1:0] cnt_q, cnt_d;
  always_comb begin
    tick  = run && cnt_q == '0;
    cnt_d = !run ? '0 : tick ? tempo : cnt_q - 1'b1;
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/synth_cfg_sequencer.sv
// synth_cfg_sequencer: pattern step sequencer sharing the cfg write port with host byte writes
module synth_cfg_sequencer #(
  parameter int STEPS_LOG2    = 4,
  parameter int TEMPO_BITS    = 16,
  parameter int CFG_ADDR_BITS = synth_pkg::CFG_ADDR_BITS,
  parameter int TARGET_ADDR   = synth_pkg::OSC_PERIOD_BASE
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     host_valid,
  output logic                     host_ready,
  input  logic [CFG_ADDR_BITS-1:0] host_addr,
  input  logic                     host_hi,
  input  logic [7:0]               host_data,
  input  logic                     pat_we,
  input  logic [STEPS_LOG2-1:0]    pat_addr,
  input  logic [15:0]              pat_data,
  input  logic                     run,
  input  logic [TEMPO_BITS-1:0]    tempo,
  input  logic [STEPS_LOG2-1:0]    last_step,
  output logic [1:0]               cfg_we,
  output logic [CFG_ADDR_BITS-1:0] cfg_w_addr,
  output logic [15:0]              cfg_w_data,
  output logic [STEPS_LOG2-1:0]    step,
  output logic                     step_tick,
  output logic                     overrun
);
  import synth_pkg::*;
  logic                     tick, seq_req, grant_host, grant_seq;
  seq_state_e               state_q, state_d;
  logic [15:0]              pat_q [2**STEPS_LOG2];
  logic [15:0]              pat_d [2**STEPS_LOG2];
  logic [15:0]              entry, word_q, word_d;
  logic [STEPS_LOG2-1:0]    step_q, step_d;
  logic                     prio_q, prio_d, step_tick_q, overrun_q, overrun_d;
  logic [1:0]               cfg_we_q, cfg_we_d;
  logic [CFG_ADDR_BITS-1:0] cfg_w_addr_q, cfg_w_addr_d;
  logic [15:0]              cfg_w_data_q, cfg_w_data_d;

  seq_tempo_counter #(.TEMPO_BITS(TEMPO_BITS)) u_tempo (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tempo (tempo),
    .tick  (tick)
  );

  // prio_q set means the host won the last contended cycle, so the sequencer goes next
  always_comb begin
    entry = pat_q[step_q];
    pat_d = pat_q;
    if (pat_we) pat_d[pat_addr] = pat_data;
    seq_req    = state_q != IDLE;
    host_ready = !reset && !(seq_req && prio_q);
    grant_host = host_valid && host_ready;
    grant_seq  = seq_req && !grant_host;
    prio_d     = (seq_req && host_valid) ? !prio_q : prio_q;
    step_d     = !run ? '0 : tick ? (step_q == last_step ? '0 : step_q + 1'b1) : step_q;
    overrun_d  = run && (overrun_q || (tick && seq_req));
    state_d    = state_q;
    word_d     = word_q;
    if (grant_seq) state_d = state_q == WR_LO ? WR_HI : IDLE;
    if (tick && !seq_req && !entry[PAT_REST_BIT]) begin
      state_d = WR_LO;
      word_d  = {1'b0, entry[PAT_REST_BIT-1:0]};
    end
    cfg_we_d     = grant_seq ? (state_q == WR_LO ? 2'b01 : 2'b10) : grant_host ? {host_hi, !host_hi} : 2'b00;
    cfg_w_addr_d = grant_seq ? CFG_ADDR_BITS'(TARGET_ADDR) : grant_host ? host_addr : '0;
    cfg_w_data_d = grant_seq ? word_q : grant_host ? {host_data, host_data} : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q        <= '{default: 16'h8000};
      state_q      <= IDLE;
      word_q       <= '0;
      step_q       <= '0;
      prio_q       <= 1'b0;
      step_tick_q  <= 1'b0;
      overrun_q    <= 1'b0;
      cfg_we_q     <= '0;
      cfg_w_addr_q <= '0;
      cfg_w_data_q <= '0;
    end else begin
      pat_q        <= pat_d;
      state_q      <= state_d;
      word_q       <= word_d;
      step_q       <= step_d;
      prio_q       <= prio_d;
      step_tick_q  <= tick;
      overrun_q    <= overrun_d;
      cfg_we_q     <= cfg_we_d;
      cfg_w_addr_q <= cfg_w_addr_d;
      cfg_w_data_q <= cfg_w_data_d;
    end
  end

  assign cfg_we     = cfg_we_q;
  assign cfg_w_addr = cfg_w_addr_q;
  assign cfg_w_data = cfg_w_data_q;
  assign step       = step_q;
  assign step_tick  = step_tick_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_synth_cfg_sequencer.sv
// tb_synth_cfg_sequencer: directed stimulus checked against a cycle-count/queue model of the sequencer
module tb_synth_cfg_sequencer;
  logic        clk = 0, reset = 1, host_valid = 0, host_hi = 0, pat_we = 0, run = 0;
  logic        host_ready, step_tick, overrun;
  logic [2:0]  host_addr = 0, cfg_w_addr;
  logic [7:0]  host_data = 0;
  logic [3:0]  pat_addr = 0, last_step = 0, step;
  logic [15:0] pat_data = 0, tempo = 0, cfg_w_data;
  logic [1:0]  cfg_we;
  int          n_checks = 0, n_errs = 0;

  always #5 clk = ~clk;

  synth_cfg_sequencer dut (
    .clk(clk), .reset(reset), .host_valid(host_valid), .host_ready(host_ready),
    .host_addr(host_addr), .host_hi(host_hi), .host_data(host_data),
    .pat_we(pat_we), .pat_addr(pat_addr), .pat_data(pat_data),
    .run(run), .tempo(tempo), .last_step(last_step),
    .cfg_we(cfg_we), .cfg_w_addr(cfg_w_addr), .cfg_w_data(cfg_w_data),
    .step(step), .step_tick(step_tick), .overrun(overrun)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pat_wr(input logic [3:0] a, input logic [15:0] d);
    pat_we = 1; pat_addr = a; pat_data = d;
    cyc();
    pat_we = 0;
  endtask

  // model: ticks at multiples of tempo+1 since run rose, step = ticks mod (last_step+1),
  // sequencer work is a count of pending bytes, arbitration alternates under contention
  logic [15:0] mem [16];
  logic [15:0] m_word, e_data;
  logic [1:0]  e_we;
  logic [2:0]  e_addr;
  logic [3:0]  e_step;
  logic        armed = 0, m_lasthost, m_ovr, e_tick, e_hr, tk, gh, gs;
  int          m_pend, m_n, m_k, cur;

  always @(negedge clk) begin
    e_hr = !reset && !(m_pend != 0 && m_lasthost);
    if (armed) begin
      chk("cfg_we", cfg_we, e_we);
      if (e_we != 0) begin
        chk("cfg_w_addr", cfg_w_addr, e_addr);
        chk("cfg_w_data", cfg_w_data, e_data);
      end
      chk("step", step, e_step);
      chk("step_tick", step_tick, e_tick);
      chk("overrun", overrun, m_ovr);
      chk("host_ready", host_ready, e_hr);
    end
    if (reset) begin
      armed = 1; m_pend = 0; m_n = 0; m_k = 0; m_lasthost = 0; m_ovr = 0; m_word = 0;
      e_we = 0; e_addr = 0; e_data = 0; e_step = 0; e_tick = 0;
      foreach (mem[i]) mem[i] = 16'h8000;
    end else begin
      gh = host_valid && e_hr;
      gs = m_pend != 0 && !gh;
      if (m_pend != 0 && host_valid) m_lasthost = gh;
      e_we   = gh ? {host_hi, !host_hi} : gs ? (m_pend == 2 ? 2'b01 : 2'b10) : 2'b00;
      e_addr = gh ? host_addr : 3'd0;
      e_data = gh ? {host_data, host_data} : m_word;
      tk     = run && (m_n % (int'(tempo) + 1) == 0);
      e_tick = tk;
      cur    = m_k % (int'(last_step) + 1);
      m_ovr  = run && (m_ovr || (tk && m_pend != 0));
      if (gs) m_pend--;
      else if (tk && m_pend == 0 && !mem[cur][15]) begin
        m_pend = 2;
        m_word = {1'b0, mem[cur][14:0]};
      end
      if (tk) m_k++;
      if (!run) begin m_k = 0; m_n = 0; end else m_n++;
      e_step = 4'(m_k % (int'(last_step) + 1));
      if (pat_we) mem[pat_addr] = pat_data;
    end
  end

  logic [1:0] t3_we   [4] = '{2'b01, 2'b01, 2'b01, 2'b10};
  logic [2:0] t3_addr [4] = '{3'd5, 3'd0, 3'd5, 3'd0};
  logic [3:0] t5_step [4] = '{4'd1, 4'd2, 4'd0, 4'd1};

  initial begin
    cyc(3);
    reset = 0;
    // lone host write
    host_valid = 1; host_addr = 3; host_hi = 1; host_data = 8'hA5;
    @(negedge clk) chk("t1_ready", host_ready, 1);
    cyc(); host_valid = 0;
    @(negedge clk);
    chk("t1_we", cfg_we, 2'b10);
    chk("t1_addr", cfg_w_addr, 3'd3);
    chk("t1_data", cfg_w_data, 16'hA5A5);
    cyc();
    @(negedge clk) chk("t1_idle", cfg_we, 2'b00);
    // pattern playback with a rest step
    pat_wr(0, 16'h0123); pat_wr(1, 16'h8000);
    last_step = 1; tempo = 9; run = 1;
    cyc(2);
    @(negedge clk);
    chk("t2_lo_we", cfg_we, 2'b01);
    chk("t2_lo_addr", cfg_w_addr, 3'd0);
    chk("t2_lo_data", cfg_w_data, 16'h0123);
    cyc();
    @(negedge clk) chk("t2_hi_we", cfg_we, 2'b10);
    cyc(9);
    @(negedge clk) chk("t2_rest", cfg_we, 2'b00);
    cyc(10);
    @(negedge clk) chk("t2_again_lo", cfg_we, 2'b01);
    cyc();
    @(negedge clk) chk("t2_again_hi", cfg_we, 2'b10);
    run = 0;
    cyc(2);
    // contention alternates host, seq, host, seq
    tempo = 100; last_step = 0;
    pat_wr(0, 16'h4321);
    run = 1;
    cyc();
    host_valid = 1; host_addr = 5; host_hi = 0; host_data = 8'h3C;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk("t3_we", cfg_we, t3_we[i]);
      chk("t3_addr", cfg_w_addr, t3_addr[i]);
    end
    cyc(); host_valid = 0; run = 0;
    cyc(2);
    // ticks faster than the write can drain
    tempo = 1; last_step = 1;
    pat_wr(0, 16'h1111); pat_wr(1, 16'h2222);
    host_valid = 1; host_addr = 6; host_hi = 1; host_data = 8'h77;
    run = 1;
    cyc(12);
    @(negedge clk) chk("t4_overrun", overrun, 1);
    run = 0;
    cyc();
    @(negedge clk) chk("t4_cleared", overrun, 0);
    cyc(); host_valid = 0;
    cyc(4);
    // tempo 0: a tick every cycle
    tempo = 0; last_step = 2;
    pat_wr(0, 16'h8000); pat_wr(1, 16'h8000); pat_wr(2, 16'h8000);
    run = 1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge clk);
      chk("t5_step", step, t5_step[i]);
      chk("t5_tick", step_tick, 1);
    end
    run = 0;
    cyc(2);
    // reset while the low byte is pending
    tempo = 50; last_step = 0;
    pat_wr(0, 16'h0ABC);
    run = 1;
    cyc();
    reset = 1;
    cyc();
    @(negedge clk);
    chk("t6_we", cfg_we, 2'b00);
    chk("t6_step", step, 0);
    chk("t6_overrun", overrun, 0);
    cyc(); reset = 0;
    cyc(6);
    @(negedge clk) chk("t6_no_write", cfg_we, 2'b00);
    run = 0;
    cyc(2);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
